// File: rtl/nv_ram_fifo_ctrl_512x32_pkg.sv
// Shared sizing defaults and pointer helper for the 512x32 RAM FIFO controller.
package nv_ram_fifo_ctrl_512x32_pkg;

    localparam int FIFO_DEPTH = 512;
    localparam int FIFO_AW    = 9;
    localparam int FIFO_DW    = 32;

    // Advance a circular RAM pointer, wrapping depth-1 back to 0.
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/nv_ram_fifo_ctrl_512x32.sv
// FIFO controller for an external 512x32 two-port RAM with a registered read
// address. The RAM's one-cycle read latency is hidden by prefetching the next
// entry into the RAM read-address register, so rd_pd comes straight from
// ram_dout. Optional status outputs (fifo_count, fifo_hwm, hwm_clr) are built
// when NV_RAM_FIFO_CTRL_STATUS_EN is defined.
module nv_ram_fifo_ctrl_512x32
    import nv_ram_fifo_ctrl_512x32_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW,
    parameter int DW    = FIFO_DW
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rstn,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic [AW-1:0] ram_wa,
    output logic          ram_we,
    output logic [DW-1:0] ram_di,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    input  logic [DW-1:0] ram_dout,
    input  logic [31:0]   pwrbus_ram_pd,
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
    output logic [AW:0]   fifo_count,
    output logic [AW:0]   fifo_hwm,
    input  logic          hwm_clr,
`endif
    output logic [31:0]   ram_pwrbus_ram_pd
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          out_vld_q, out_vld_d;
    logic [AW:0]   pending;
    logic          push;
    logic          pop;

    // Handshakes, RAM port drive and next-state for pointers, count and output valid.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;

        // Full is judged on the registered count, so a pop while full frees a slot only next cycle.
        wr_prdy   = (count_q != (AW+1)'(DEPTH));
        push      = wr_pvld & wr_prdy;
        pop       = out_vld_q & rd_prdy;

        // Entries sitting in RAM that have not been fetched; the held output still counts as occupied.
        pending   = count_q - {{AW{1'b0}}, out_vld_q};
        // Fetch only when the output slot is free or being drained; this keeps rd_pd stable on a stall.
        ram_re    = (pending != '0) & (~out_vld_q | rd_prdy);
        ram_ra    = rd_ptr_q;

        ram_we    = push;
        ram_wa    = wr_ptr_q;
        ram_di    = wr_pd;

        rd_pvld   = out_vld_q;
        rd_pd     = ram_dout;
        out_vld_d = ram_re | (out_vld_q & ~rd_prdy);

        if (push) begin
            wr_ptr_d = AW'(ptr_inc(32'(wr_ptr_q), DEPTH));
        end
        if (ram_re) begin
            rd_ptr_d = AW'(ptr_inc(32'(rd_ptr_q), DEPTH));
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // Controller state registers; reset discards every entry including the held output.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            out_vld_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
    logic [AW:0] hwm_q, hwm_d;

    // High-water mark tracks the largest registered count; hwm_clr restarts it from the current count.
    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr) begin
            hwm_d = count_q;
        end else if (count_q > hwm_q) begin
            hwm_d = count_q;
        end
    end

    // High-water mark register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign fifo_count = count_q;
    assign fifo_hwm   = hwm_q;
`endif

endmodule

// File: tb/tb_nv_ram_fifo_ctrl_512x32.sv
// Self-checking bench for nv_ram_fifo_ctrl_512x32 with a behavioural 512x32 RAM
// (registered read address, combinational data). A queue scoreboard holds every
// accepted word; a negedge monitor checks handshakes, RAM writes, output order
// and stall stability. Status checks are built when NV_RAM_FIFO_CTRL_STATUS_EN is defined.
module tb_nv_ram_fifo_ctrl_512x32;

    localparam int DEPTH = 512;
    localparam int AW    = 9;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic [AW-1:0] ram_wa;
    logic          ram_we;
    logic [DW-1:0] ram_di;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic [DW-1:0] ram_dout;
    logic [31:0]   pwrbus_ram_pd;
    logic [31:0]   ram_pwrbus_ram_pd;
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
    logic [AW:0]   fifo_count;
    logic [AW:0]   fifo_hwm;
    logic          hwm_clr;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] expq[$];
    int            wr_addr_m;
    logic          prev_stall;
    logic [DW-1:0] prev_pd;
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
    int            hwm_m;
`endif

    always #5 clk = ~clk;

    nv_ram_fifo_ctrl_512x32 dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rstn   (rstn),
        .wr_pvld           (wr_pvld),
        .wr_prdy           (wr_prdy),
        .wr_pd             (wr_pd),
        .rd_pvld           (rd_pvld),
        .rd_prdy           (rd_prdy),
        .rd_pd             (rd_pd),
        .ram_wa            (ram_wa),
        .ram_we            (ram_we),
        .ram_di            (ram_di),
        .ram_ra            (ram_ra),
        .ram_re            (ram_re),
        .ram_dout          (ram_dout),
        .pwrbus_ram_pd     (pwrbus_ram_pd),
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
        .fifo_count        (fifo_count),
        .fifo_hwm          (fifo_hwm),
        .hwm_clr           (hwm_clr),
`endif
        .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
    );

    // Behavioural two-port RAM: registered read address, combinational read data.
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] ra_reg;
    always @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_reg <= ram_ra;
    end
    assign ram_dout = mem[ra_reg];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: model occupancy is the queue size; words leave in push order.
    always @(negedge clk) begin
        int sz;
        sz = expq.size();
        if (!rstn) begin
            expq.delete();
            wr_addr_m  = 0;
            prev_stall = 1'b0;
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
            hwm_m = 0;
`endif
            check("rst_rd_pvld", 32'(rd_pvld), 32'd0);
            check("rst_wr_prdy", 32'(wr_prdy), 32'd1);
            check("rst_ram_we",  32'(ram_we),  32'd0);
            check("rst_ram_re",  32'(ram_re),  32'd0);
        end else begin
            check("wr_prdy", 32'(wr_prdy), 32'(sz != DEPTH));
            check("ram_we",  32'(ram_we),  32'(wr_pvld && sz != DEPTH));
            if (wr_pvld && sz != DEPTH) begin
                check("ram_wa", 32'(ram_wa), 32'(wr_addr_m));
                check("ram_di", ram_di, wr_pd);
            end
            if (rd_pvld) check("rd_pvld_nonempty", 32'(sz != 0), 32'd1);
            if (prev_stall) begin
                check("hold_vld", 32'(rd_pvld), 32'd1);
                check("hold_pd",  rd_pd, prev_pd);
            end
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
            check("fifo_count", 32'(fifo_count), 32'(sz));
            check("fifo_hwm",   32'(fifo_hwm),   32'(hwm_m));
            hwm_m = hwm_clr ? sz : ((sz > hwm_m) ? sz : hwm_m);
`endif
            if (rd_pvld && rd_prdy && sz != 0) begin
                check("rd_pd", rd_pd, expq.pop_front());
            end
            if (wr_pvld && sz != DEPTH) begin
                expq.push_back(wr_pd);
                wr_addr_m = (wr_addr_m + 1) % DEPTH;
            end
            prev_stall = rd_pvld && !rd_prdy;
            prev_pd    = rd_pd;
        end
    end

    task automatic drain(input int budget);
        int n;
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (expq.size() == 0 && !rd_pvld) break;
            n++;
            if (n > budget) begin
                errors++;
                $display("FAIL drain_timeout: %0d words left after %0d cycles", expq.size(), budget);
                break;
            end
        end
        next_cycle();
    endtask

    initial begin
        int sent;
        int cyc;
        rstn          = 1'b0;
        wr_pvld       = 1'b0;
        wr_pd         = '0;
        rd_prdy       = 1'b0;
        pwrbus_ram_pd = 32'h1357_9BDF;
`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
        hwm_clr       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("pwrbus", ram_pwrbus_ram_pd, 32'h1357_9BDF);
        rstn = 1'b1;

        // Single word latency: we at cycle 0, re at 1, data at 2, gone at 3.
        next_cycle();
        wr_pvld = 1'b1; wr_pd = 32'hA5A5_0001; rd_prdy = 1'b1;
        @(negedge clk);
        check("t1_c0_we",  32'(ram_we),  32'd1);
        check("t1_c0_re",  32'(ram_re),  32'd0);
        check("t1_c0_vld", 32'(rd_pvld), 32'd0);
        next_cycle();
        wr_pvld = 1'b0;
        @(negedge clk);
        check("t1_c1_re",  32'(ram_re),  32'd1);
        check("t1_c1_ra",  32'(ram_ra),  32'd0);
        check("t1_c1_vld", 32'(rd_pvld), 32'd0);
        next_cycle();
        @(negedge clk);
        check("t1_c2_vld", 32'(rd_pvld), 32'd1);
        check("t1_c2_pd",  rd_pd, 32'hA5A5_0001);
        next_cycle();
        @(negedge clk);
        check("t1_c3_vld", 32'(rd_pvld), 32'd0);

        // Fill to full with the reader stalled.
        next_cycle();
        rd_prdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_pvld = 1'b1; wr_pd = 32'(i);
            next_cycle();
        end
        wr_pd = 32'd999;
        @(negedge clk);
        check("full_wr_prdy", 32'(wr_prdy), 32'd0);
        check("full_no_we",   32'(ram_we),  32'd0);
        check("full_vld",     32'(rd_pvld), 32'd1);
        check("full_pd",      rd_pd, 32'd0);

        // From full: pop and push together; the first cycle only pops.
        next_cycle();
        rd_prdy = 1'b1; wr_pvld = 1'b1; wr_pd = 32'd1000;
        @(negedge clk);
        check("fullpop_no_we", 32'(ram_we), 32'd0);
        check("fullpop_vld",   32'(rd_pvld), 32'd1);
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            wr_pd = 32'(1000 + i);
            @(negedge clk);
            check("steady_wr_prdy", 32'(wr_prdy), 32'd1);
            check("steady_rd_pvld", 32'(rd_pvld), 32'd1);
        end
        next_cycle();
        drain(2000);

        // Random stream of 1200 words with stalls on both sides.
        sent = 0;
        cyc  = 0;
        while (sent < 1200 && cyc < 20000) begin
            wr_pvld = ($urandom_range(0, 3) != 0);
            rd_prdy = ($urandom_range(0, 3) != 0);
            wr_pd   = 32'h5000_0000 + 32'(sent);
            @(negedge clk);
            if (wr_pvld && wr_prdy) sent++;
            cyc++;
            next_cycle();
        end
        if (sent < 1200) begin
            errors++;
            $display("FAIL stream_timeout: sent %0d of 1200", sent);
        end
        drain(3000);

        // Asynchronous reset in the middle of a transfer.
        rd_prdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_pvld = 1'b1; wr_pd = $urandom;
            next_cycle();
        end
        wr_pvld = 1'b0;
        #2;
        check("pre_rst_vld", 32'(rd_pvld), 32'd1);
        rstn = 1'b0;
        #1;
        check("async_rst_vld",  32'(rd_pvld), 32'd0);
        check("async_rst_prdy", 32'(wr_prdy), 32'd1);
        next_cycle();
        rstn = 1'b1;
        next_cycle();
        wr_pvld = 1'b1; wr_pd = 32'hDEAD_BEEF; rd_prdy = 1'b1;
        next_cycle();
        wr_pvld = 1'b0;
        cyc = 0;
        forever begin
            @(negedge clk);
            if (rd_pvld) break;
            cyc++;
            if (cyc > 10) begin
                errors++;
                $display("FAIL post_rst_timeout: rd_pvld never rose");
                break;
            end
        end
        check("post_rst_first", rd_pd, 32'hDEAD_BEEF);
        next_cycle();
        drain(100);

`ifdef NV_RAM_FIFO_CTRL_STATUS_EN
        // Status: push 300, pop 300, then clear the high-water mark.
        rd_prdy = 1'b0;
        for (int i = 0; i < 300; i++) begin
            wr_pvld = 1'b1; wr_pd = 32'h7000_0000 + 32'(i);
            next_cycle();
        end
        drain(1000);
        next_cycle();
        @(negedge clk);
        check("st_count", 32'(fifo_count), 32'd0);
        check("st_hwm",   32'(fifo_hwm),   32'd300);
        next_cycle();
        hwm_clr = 1'b1;
        next_cycle();
        hwm_clr = 1'b0;
        @(negedge clk);
        check("st_hwm_clr", 32'(fifo_hwm), 32'd0);
`endif

        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/nv_ram_fifo_ctrl_512x32.md
Name: nv_ram_fifo_ctrl_512x32

Overview:
Synchronous FIFO controller that drives the write and read ports of an external 512x32 two-port RAM with a registered read address (rws type). It presents valid/ready push and pop interfaces. It hides the RAM's one-cycle read latency by prefetching into the RAM's read-address register. The parent instantiates the RAM beside this block and wires the ram_* ports straight through.

Parameters:
DEPTH, 512, number of RAM entries; must equal 2**AW.
AW, 9, RAM address width.
DW, 32, data width.

Ports:
nvdla_core_clk  input  1  core clock; RAM shares it.
nvdla_core_rstn  input  1  asynchronous active-low reset.
wr_pvld  input  1  push valid.
wr_prdy  output  1  push ready.
wr_pd  input  DW  push data.
rd_pvld  output  1  pop valid.
rd_prdy  input  1  pop ready.
rd_pd  output  DW  pop data.
ram_wa  output  AW  RAM write address.
ram_we  output  1  RAM write enable.
ram_di  output  DW  RAM write data.
ram_ra  output  AW  RAM read address.
ram_re  output  1  RAM read-address register enable.
ram_dout  input  DW  RAM read data: M[registered ra], combinational.
pwrbus_ram_pd  input  32  power bus; passed to ram_pwrbus_ram_pd unchanged.
ram_pwrbus_ram_pd  output  32  power bus to RAM.

Behaviour:
- Reset clears the following to 0: wr_ptr, rd_ptr, count (AW+1 bits), out_vld.
- Outputs after reset: rd_pvld=0, wr_prdy=1, ram_we=0, ram_re=0. RAM contents are not cleared.
- Push: push = wr_pvld & wr_prdy; wr_prdy = (count != DEPTH).
  - On push: ram_we=1, ram_wa=wr_ptr, ram_di=wr_pd (all combinational); wr_ptr increments and wraps DEPTH-1 -> 0.
- Pending RAM entries = count - out_vld, i.e. entries written but not yet fetched.
- Fetch: ram_re = (pending != 0) & (!out_vld | rd_prdy); ram_ra = rd_ptr.
  - On fetch, rd_ptr increments and wraps; out_vld <= 1 at the next edge.
- Pop: pop = out_vld & rd_prdy. rd_pvld = out_vld; rd_pd = ram_dout (no extra flop).
  - Data is valid one cycle after ram_re.
  - out_vld <= ram_re | (out_vld & !rd_prdy).
- Throughput: one push and one pop per cycle in steady state.
- Latency: a push at edge t produces rd_pvld in cycle t+2 at the earliest (empty FIFO).
- Count: count <= count + push - pop. A simultaneous push and pop leaves count unchanged.
- Hazard rules:
  - The fetch decision uses count from before the current push, so an entry is never fetched in the cycle it is written (no flow-through).
  - The held entry counts as occupied, so its address is not rewritten while rd_pvld=1.
  - Full + pop in the same cycle: no push that cycle, because wr_prdy is computed from the registered count.
- rd_pd must stay stable while rd_pvld=1 and rd_prdy=0: ram_re is 0 in that case.
- Empty: rd_pvld=0, ram_re=0; rd_prdy is ignored.
- Full: count=DEPTH, wr_prdy=0; wr_pvld is ignored with no write.
- Wrap-around: pointers wrap independently; the full/empty decision uses count only.
- Reset mid-operation discards all entries, including any held output, immediately (asynchronous).

Optional Feature:
NV_RAM_FIFO_CTRL_STATUS_EN
- Defined: adds output fifo_count[AW:0] = count (registered) and output fifo_hwm[AW:0], a high-water mark.
  - fifo_hwm updates to max(fifo_hwm, count) each cycle and resets to 0.
  - Adds input hwm_clr (1 bit, synchronous): clears fifo_hwm to the current count.
- Undefined: these ports and the registers are absent; core behaviour is identical.

Decomposition:
- Shared package/include: DEPTH, AW, DW defaults and the pointer-increment-with-wrap function.
- No sub-module. The RAM is instantiated by the parent, not inside this block.

Test Plan:
- Reset, then push 0xA5A5_0001 at cycle 0 with rd_prdy=1 -> ram_we at cycle 0, ram_re at cycle 1, rd_pvld=1 with rd_pd=0xA5A5_0001 at cycle 2, and rd_pvld=0 at cycle 3.
- With rd_prdy=0, push 512 words 0..511 -> wr_prdy falls after the 512th push; a 513th wr_pvld causes no ram_we; rd_pd holds 0 without changing.
- From full, assert rd_prdy=1 and wr_pvld=1 together -> first cycle: pop only, count goes 512->511; from then on, one push and one pop per cycle with count steady at 511.
- Stream 1200 words with random rd_prdy stalls -> output order is exact (covers pointer wrap twice); rd_pd is stable on every stalled cycle.
- Fill with 5 words, drop nvdla_core_rstn mid-transfer -> rd_pvld=0 and wr_prdy=1 immediately; after release, push 0xDEAD_BEEF -> it is the first word out.
- With NV_RAM_FIFO_CTRL_STATUS_EN: push 300, pop 300 -> fifo_count ends at 0 and fifo_hwm=300; hwm_clr -> fifo_hwm=0.
